lpc_host_sched: RTL and testbench

- Round-robin scheduler sharing one lpc_host instance between NUM_REQ requesters.
- Latches one request and sequences the host control strobes: lframe low, then cycle-type strobe.
- Waits for completion and returns read data and status to the owning requester.
- Detects host error resets and timeouts, then recovers the host via ctrl_nrst before serving the next request.

---
 rtl/lpc_host_sched_pkg.sv | 24 ++
 rtl/lpc_rr_arbiter.sv | 34 +++
 rtl/lpc_host_sched.sv | 164 ++++++++++++++++
 tb/tb_lpc_host_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_host_sched_pkg.sv
// Shared codes for the LPC host scheduler: host state decodes, scheduler states, helpers.
package lpc_host_sched_pkg;

  // lpc_host state codes the scheduler decodes
  localparam logic [4:0] LPC_ST_IDLE        = 5'h00;
  localparam logic [4:0] LPC_ST_START       = 5'h01;
  localparam logic [4:0] LPC_ST_FORCE_RESET = 5'h1f;

  typedef enum logic [2:0] {
    LPC_SCHED_ST_RST_HOLD,
    LPC_SCHED_ST_SETTLE,
    LPC_SCHED_ST_IDLE,
    LPC_SCHED_ST_FRAME,
    LPC_SCHED_ST_CYC,
    LPC_SCHED_ST_WAIT,
    LPC_SCHED_ST_RSP,
    LPC_SCHED_ST_RECOVER
  } sched_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lpc_rr_arbiter.sv
// Combinational round-robin pick: lowest requester index at or after the pointer.
module lpc_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx
);

  // position ptr+k folded back into 0..NUM_REQ-1
  function automatic logic [PW-1:0] rr_pos(input logic [PW-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    if (j >= NUM_REQ) j = j - NUM_REQ;
    return PW'(j);
  endfunction

  // scan from farthest to nearest so the nearest requester overwrites the pick
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (en && req[rr_pos(ptr, k)]) begin
        grant                 = '0;
        grant[rr_pos(ptr, k)] = 1'b1;
        idx                   = rr_pos(ptr, k);
      end
    end
  end

endmodule

// File: rtl/lpc_host_sched.sv
// Round-robin scheduler sharing one lpc_host between NUM_REQ requesters, with
// error/timeout detection and host recovery through ctrl_nrst. All outputs registered.
module lpc_host_sched
  import lpc_host_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64,
  parameter int RST_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_write_i,
  input  logic [NUM_REQ-1:0]   req_mem_i,
  input  logic [16*NUM_REQ-1:0] req_addr_i,
  input  logic [8*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]   req_ack_o,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic                 rsp_err_o,
  output logic [7:0]           rsp_rdata_o,
  output logic [15:0]          ctrl_addr_o,
  output logic [7:0]           ctrl_data_o,
  output logic                 ctrl_nrst_o,
  output logic                 ctrl_lframe_o,
  output logic                 ctrl_rd_status_o,
  output logic                 ctrl_wr_status_o,
  output logic                 ctrl_memory_cycle_o,
  input  logic [7:0]           ctrl_data_i,
  input  logic                 ctrl_ready_i,
  input  logic [4:0]           ctrl_host_state_i
);

  localparam int PW    = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(TIMEOUT, RST_CYCLES)) + 1;

  // every registered bit of the scheduler, outputs included
  typedef struct packed {
    sched_state_t       st;
    logic [CNT_W-1:0]   cnt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      owner;
    logic               wr;
    logic               err;
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] rsp;
    logic [15:0]        addr;
    logic [7:0]         wdata;
    logic [7:0]         rdata;
    logic               nrst;
    logic               lframe;
    logic               rd_strb;
    logic               wr_strb;
    logic               mem;
  } regs_t;

  regs_t q, d;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      gidx;

  lpc_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req   (req_valid_i),
    .ptr   (q.ptr),
    .en    (q.st == LPC_SCHED_ST_IDLE),
    .grant (grant),
    .idx   (gidx)
  );

  // state and output register; reset holds the host in reset with lframe idle
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      q        <= '0;
      q.st     <= LPC_SCHED_ST_RST_HOLD;
      q.lframe <= 1'b1;
    end else begin
      q <= d;
    end
  end

  // next state and next registered outputs; ack/rsp are single-cycle pulses
  always_comb begin
    d     = q;
    d.ack = '0;
    d.rsp = '0;
    case (q.st)
      LPC_SCHED_ST_RST_HOLD, LPC_SCHED_ST_RECOVER: begin
        if (q.cnt == CNT_W'(RST_CYCLES-1)) begin
          d.nrst = 1'b1;
          d.cnt  = '0;
          d.st   = LPC_SCHED_ST_SETTLE;
        end else begin
          d.cnt = q.cnt + 1'b1;
        end
      end
      LPC_SCHED_ST_SETTLE:
        if (ctrl_host_state_i == LPC_ST_IDLE) d.st = LPC_SCHED_ST_IDLE;
      LPC_SCHED_ST_IDLE:
        if (|req_valid_i) begin
          d.owner  = gidx;
          d.ack    = grant;
          d.addr   = req_addr_i[int'(gidx)*16 +: 16];
          d.wdata  = req_wdata_i[int'(gidx)*8 +: 8];
          d.wr     = req_write_i[gidx];
          d.mem    = req_mem_i[gidx];
          d.ptr    = (int'(gidx) == NUM_REQ-1) ? '0 : gidx + 1'b1;
          d.lframe = 1'b0;
          d.st     = LPC_SCHED_ST_FRAME;
        end
      LPC_SCHED_ST_FRAME:
        if (ctrl_host_state_i == LPC_ST_START) begin
          d.lframe  = 1'b1;
          d.wr_strb = q.wr;
          d.rd_strb = ~q.wr;
          d.st      = LPC_SCHED_ST_CYC;
        end
      LPC_SCHED_ST_CYC:
        if (ctrl_host_state_i != LPC_ST_START) begin
          d.wr_strb = 1'b0;
          d.rd_strb = 1'b0;
          d.cnt     = '0;
          d.st      = LPC_SCHED_ST_WAIT;
        end
      LPC_SCHED_ST_WAIT: begin
        d.cnt = q.cnt + 1'b1;
        if (ctrl_host_state_i == LPC_ST_FORCE_RESET) begin
          d.rsp[q.owner] = 1'b1;
          d.err          = 1'b1;
          d.st           = LPC_SCHED_ST_RSP;
        end else if (ctrl_ready_i) begin
          d.rsp[q.owner] = 1'b1;
          d.err          = 1'b0;
          if (!q.wr) d.rdata = ctrl_data_i;
          d.st           = LPC_SCHED_ST_RSP;
        end else if (q.cnt == CNT_W'(TIMEOUT-1)) begin
          d.rsp[q.owner] = 1'b1;
          d.err          = 1'b1;
          d.st           = LPC_SCHED_ST_RSP;
        end
      end
      LPC_SCHED_ST_RSP: begin
        if (q.err) begin
          d.nrst = 1'b0;
          d.cnt  = '0;
          d.st   = LPC_SCHED_ST_RECOVER;
        end else begin
          d.st = LPC_SCHED_ST_IDLE;
        end
      end
      default: d.st = LPC_SCHED_ST_RST_HOLD;
    endcase
  end

  assign req_ack_o           = q.ack;
  assign rsp_valid_o         = q.rsp;
  assign rsp_err_o           = q.err;
  assign rsp_rdata_o         = q.rdata;
  assign ctrl_addr_o         = q.addr;
  assign ctrl_data_o         = q.wdata;
  assign ctrl_nrst_o         = q.nrst;
  assign ctrl_lframe_o       = q.lframe;
  assign ctrl_rd_status_o    = q.rd_strb;
  assign ctrl_wr_status_o    = q.wr_strb;
  assign ctrl_memory_cycle_o = q.mem;

endmodule

// File: tb/tb_lpc_host_sched.sv
// Scoreboard bench: requester drivers, a behavioural host model, and a monitor
// that predicts grants/responses from the round-robin and transaction rules.
module tb_lpc_host_sched;
  import lpc_host_sched_pkg::*;

  localparam int N  = 4;
  localparam int TO = 64;
  localparam int RC = 4;
  localparam logic [4:0] H_RST  = 5'h10;
  localparam logic [4:0] H_XFER = 5'h05;
  localparam int M_OK = 0, M_BAD = 1, M_STUCK = 2;

  typedef struct {
    logic wr; logic mem; logic [15:0] addr; logic [7:0] wdata;
    int mode; int dly; logic [7:0] dev;
  } txn_t;
  typedef struct { int g; logic err; logic [7:0] rdata; logic stuck; } exp_t;

  logic clk = 0, nrst = 1;
  logic [N-1:0] req_valid = '0, req_write = '0, req_mem = '0;
  logic [16*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0] req_ack_o, rsp_valid_o;
  logic rsp_err_o, ctrl_nrst_o, ctrl_lframe_o, ctrl_rd_status_o, ctrl_wr_status_o, ctrl_memory_cycle_o;
  logic [7:0] rsp_rdata_o, ctrl_data_o;
  logic [15:0] ctrl_addr_o;
  logic [7:0] hdata = '0;
  logic hready = 1'b0;
  logic [4:0] hst = H_RST;

  lpc_host_sched #(.NUM_REQ(N), .TIMEOUT(TO), .RST_CYCLES(RC)) dut (
    .clk_i(clk), .nrst_i(nrst),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_mem_i(req_mem),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ack_o(req_ack_o), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
    .rsp_rdata_o(rsp_rdata_o), .ctrl_addr_o(ctrl_addr_o), .ctrl_data_o(ctrl_data_o),
    .ctrl_nrst_o(ctrl_nrst_o), .ctrl_lframe_o(ctrl_lframe_o),
    .ctrl_rd_status_o(ctrl_rd_status_o), .ctrl_wr_status_o(ctrl_wr_status_o),
    .ctrl_memory_cycle_o(ctrl_memory_cycle_o), .ctrl_data_i(hdata),
    .ctrl_ready_i(hready), .ctrl_host_state_i(hst)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // stimulus records shared with the monitor
  txn_t txq[N][$];
  logic [N-1:0] busy = '0;
  int   iss[N];
  int   pend_t[N];
  txn_t pend_tx[N];

  // requester drivers: present the next queued transaction once the previous one responded
  initial begin
    txn_t t;
    for (int i = 0; i < N; i++) begin iss[i] = 0; pend_t[i] = 0; end
    forever begin
      @(negedge clk);
      if (!nrst) begin
        req_valid = '0;
        busy = '0;
        for (int i = 0; i < N; i++) txq[i].delete();
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req_ack_o[i]) begin req_valid[i] = 1'b0; busy[i] = 1'b1; end
          if (rsp_valid_o[i]) busy[i] = 1'b0;
          if (!busy[i] && !req_valid[i] && txq[i].size() > 0) begin
            t = txq[i].pop_front();
            req_valid[i] = 1'b1;
            req_write[i] = t.wr;
            req_mem[i]   = t.mem;
            req_addr[i*16 +: 16] = t.addr;
            req_wdata[i*8 +: 8]  = t.wdata;
            pend_tx[i] = t;
            pend_t[i]  = cyc;
            iss[i]++;
          end
        end
      end
    end
  end

  // monitor + reference model + host model
  exp_t expq[$];
  int   gseq[$];
  int   tak[N];
  int   ptr = 0, run = 0, wait_entry = 0, hcnt = 0;
  logic [7:0] last_rd = '0;
  txn_t cur;
  initial begin
    exp_t e;
    int g, j;
    for (int i = 0; i < N; i++) tak[i] = 0;
    cur = '{wr: 1'b0, mem: 1'b0, addr: 16'h0, wdata: 8'h0, mode: M_OK, dly: 0, dev: 8'h0};
    forever begin
      @(negedge clk);
      if (!nrst) begin
        ptr = 0; last_rd = '0; run = 0;
        expq.delete();
        for (int i = 0; i < N; i++) tak[i] = iss[i];
        chk("rsp_in_reset", 64'(rsp_valid_o), 64'h0);
      end else begin
        if (!ctrl_nrst_o) run++;
        else if (run > 0) begin chk("nrst_low_cycles", 64'(run), 64'(RC)); run = 0; end
        if (rsp_valid_o != '0) begin
          if (expq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid_o), 64'h0);
          else begin
            e = expq.pop_front();
            chk("rsp_owner", 64'(rsp_valid_o), 64'(1) << e.g);
            chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
            if (!e.err) chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
            if (e.stuck) chk("timeout_latency", 64'(cyc - wait_entry), 64'(TO));
          end
        end
        if (req_ack_o != '0) begin
          g = -1;
          for (int k = N-1; k >= 0; k--) begin
            j = (ptr + k) % N;
            if (tak[j] != iss[j] && pend_t[j] < cyc) g = j;
          end
          if (g < 0) chk("ack_unexpected", 64'(req_ack_o), 64'h0);
          else begin
            chk("ack_grant", 64'(req_ack_o), 64'(1) << g);
            gseq.push_back(g);
            tak[g]++;
            ptr = (g + 1) % N;
            cur = pend_tx[g];
            e.g = g;
            e.err = (cur.mode != M_OK);
            e.stuck = (cur.mode == M_STUCK);
            if (cur.mode == M_OK && !cur.wr) last_rd = cur.dev;
            e.rdata = last_rd;
            expq.push_back(e);
          end
        end
      end
      // host model
      if (!ctrl_nrst_o) begin
        hst = H_RST; hready = 1'b0;
      end else begin
        case (hst)
          H_RST: hst = LPC_ST_IDLE;
          LPC_ST_IDLE:
            if (!ctrl_lframe_o) begin hst = LPC_ST_START; hready = 1'b0; hdata = 8'($urandom); end
          LPC_ST_START:
            if (ctrl_rd_status_o || ctrl_wr_status_o) begin
              chk("strobe", 64'({ctrl_rd_status_o, ctrl_wr_status_o}), cur.wr ? 64'h1 : 64'h2);
              chk("cycle_type", 64'({1'b0, ctrl_memory_cycle_o, ctrl_wr_status_o, 1'b0}),
                  64'({1'b0, cur.mem, cur.wr, 1'b0}));
              chk("ctrl_addr", 64'(ctrl_addr_o), 64'(cur.addr));
              if (cur.wr) chk("ctrl_wdata", 64'(ctrl_data_o), 64'(cur.wdata));
              hst = H_XFER; hcnt = cur.dly; wait_entry = cyc + 1;
            end
          H_XFER:
            if (hcnt > 0) hcnt--;
            else if (cur.mode == M_OK) begin hready = 1'b1; hdata = cur.dev; hst = LPC_ST_IDLE; end
            else if (cur.mode == M_BAD) hst = LPC_ST_FORCE_RESET;
          default: ;
        endcase
      end
    end
  end

  function automatic txn_t mk(input logic wr, input logic mem, input logic [15:0] addr,
                              input logic [7:0] wd, input logic [7:0] dev, input int mode);
    txn_t t;
    t.wr = wr; t.mem = mem; t.addr = addr; t.wdata = wd; t.dev = dev; t.mode = mode;
    t.dly = $urandom_range(0, 8);
    return t;
  endfunction

  function automatic txn_t rnd(input int mode);
    return mk(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), mode);
  endfunction

  task automatic drain(input int limit);
    int n = 0;
    while (n < limit && !(txq[0].size() == 0 && txq[1].size() == 0 && txq[2].size() == 0 &&
           txq[3].size() == 0 && busy == '0 && req_valid == '0 && expq.size() == 0 &&
           hst == LPC_ST_IDLE && ctrl_nrst_o)) begin
      @(negedge clk); n++;
    end
    chk("drain_in_bound", 64'(n < limit), 64'h1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ctrl", 64'({ctrl_nrst_o, ctrl_lframe_o, ctrl_rd_status_o, ctrl_wr_status_o,
                          ctrl_memory_cycle_o}), 64'b01000);
    chk("rst_handshake", 64'({req_ack_o, rsp_valid_o, rsp_err_o}), 64'h0);
    chk("rst_data", 64'({ctrl_addr_o, ctrl_data_o, rsp_rdata_o}), 64'h0);
  endtask

  initial begin
    int gs, n, r;
    int ord[6] = '{0, 1, 3, 0, 1, 3};
    #2 nrst = 1'b0;
    #1 chk_reset_outputs();
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // 0,1,3 contending, two transactions each
    gs = gseq.size();
    for (int k = 0; k < 2; k++) begin
      txq[0].push_back(rnd(M_OK)); txq[1].push_back(rnd(M_OK)); txq[3].push_back(rnd(M_OK));
    end
    drain(2000);
    chk("rr_count", 64'(gseq.size() - gs), 64'h6);
    for (int k = 0; k < 6; k++)
      if (gs + k < gseq.size()) chk("rr_order", 64'(gseq[gs+k]), 64'(ord[k]));

    // single I/O read
    txq[0].push_back(mk(1'b0, 1'b0, 16'h0080, 8'h00, 8'hA5, M_OK));
    drain(500);
    chk("io_read_rdata", 64'(rsp_rdata_o), 64'hA5);

    // memory write
    txq[2].push_back(mk(1'b1, 1'b1, 16'h1234, 8'h5A, 8'h00, M_OK));
    drain(500);

    // bad sync on 3, normal read queued on 0
    gs = gseq.size();
    txq[3].push_back(rnd(M_BAD));
    txq[0].push_back(mk(1'b0, 1'b1, 16'hBEEF, 8'h00, 8'h3C, M_OK));
    drain(1000);
    chk("err_then_next_count", 64'(gseq.size() - gs), 64'h2);
    if (gseq.size() - gs == 2) begin
      chk("err_first", 64'(gseq[gs]), 64'h3);
      chk("next_after_err", 64'(gseq[gs+1]), 64'h0);
    end

    // device hangs: timeout
    txq[2].push_back(mk(1'b0, 1'b0, 16'h0060, 8'h00, 8'h00, M_STUCK));
    drain(1000);

    // random mix
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      txq[$urandom_range(0, N-1)].push_back(rnd(r == 0 ? M_BAD : (r == 1 ? M_STUCK : M_OK)));
    end
    drain(20000);

    // reset while waiting on the device
    txq[1].push_back(mk(1'b0, 1'b0, 16'h0070, 8'h00, 8'h00, M_STUCK));
    n = 0;
    while (hst != H_XFER && n < 500) begin @(negedge clk); n++; end
    chk("reach_wait", 64'(n < 500), 64'h1);
    repeat (5) @(posedge clk);
    #2 nrst = 1'b0;
    #1 chk_reset_outputs();
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    for (int k = 0; k < 10; k++) txq[$urandom_range(0, N-1)].push_back(rnd(M_OK));
    drain(5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
